// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream slave receiver.
package axis_pkg;

    typedef enum logic {IDLE, RECV} axis_rx_state_t;

    localparam int unsigned AXIS_DATA_W = 32;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

    // Width needed to hold a beat count in the range 0..max_beats.
    function automatic int unsigned beat_cnt_w(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/axis_slave_rx_if.sv
// Stream and consumer-side signals of axis_slave_rx; master = environment, slave = receiver.
interface axis_slave_rx_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  tvalid_in;
    logic [DATA_WIDTH-1:0] tdata_in;
    logic                  tlast_in;
    logic                  tready_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  last_out;
    logic                  valid_out;
    logic                  read_in;
    logic                  pkt_done_out;
    logic                  len_err_out;

    modport master (
        output tvalid_in, tdata_in, tlast_in, read_in,
        input  tready_out, data_out, last_out, valid_out, pkt_done_out, len_err_out
    );

    modport slave (
        input  tvalid_in, tdata_in, tlast_in, read_in,
        output tready_out, data_out, last_out, valid_out, pkt_done_out, len_err_out
    );
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with show-ahead head entry; head reads as zero while empty.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/axis_slave_rx.sv
// AXI-Stream slave receiver: buffers beats in a FIFO, tracks packets, pulses done per packet.
// Optional length check enabled by defining AXIS_SLAVE_LEN_CHECK_EN.
module axis_slave_rx
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_BEATS  = 256
) (
    input  logic           CLK,
    input  logic           RST,
    axis_slave_rx_if.slave axis
);
    localparam int unsigned BEAT_W = DATA_WIDTH + 1;
    localparam int unsigned CNT_W  = beat_cnt_w(MAX_BEATS);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    axis_rx_state_t   state_q, state_nx;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_nx;
    logic             rdy_q;
    logic             pkt_done_q;
    logic             full, empty;
    logic             tready;
    logic             accept;
    logic             force_last;
    logic             eff_last;
    beat_t            wr_beat, rd_beat;

    assign tready   = rdy_q && !full;
    assign accept   = axis.tvalid_in && tready;

`ifdef AXIS_SLAVE_LEN_CHECK_EN
    logic len_err_q;
    // The beat about to be accepted is number beat_cnt_q+1.
    assign force_last = (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) && !axis.tlast_in;
`else
    assign force_last = 1'b0;
`endif

    assign eff_last = axis.tlast_in || force_last;
    assign wr_beat  = '{last: eff_last, data: axis.tdata_in};

    axis_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (accept),
        .wr_data (wr_beat),
        .rd_en   (axis.read_in),
        .rd_data (rd_beat),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_nx    = state_q;
        beat_cnt_nx = beat_cnt_q;
        if (accept) begin
            if (eff_last) begin
                state_nx    = IDLE;
                beat_cnt_nx = '0;
            end else begin
                state_nx = RECV;
                if (beat_cnt_q != CNT_W'(MAX_BEATS)) beat_cnt_nx = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            rdy_q      <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_nx;
            beat_cnt_q <= beat_cnt_nx;
            rdy_q      <= 1'b1;
            pkt_done_q <= accept && eff_last;
        end
    end

`ifdef AXIS_SLAVE_LEN_CHECK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) len_err_q <= 1'b0;
        else if (accept && force_last) len_err_q <= 1'b1;
    end
    assign axis.len_err_out = len_err_q;
`else
    assign axis.len_err_out = 1'b0;
`endif

    assign axis.tready_out   = tready;
    assign axis.data_out     = rd_beat.data;
    assign axis.last_out     = rd_beat.last;
    assign axis.valid_out    = !empty;
    assign axis.pkt_done_out = pkt_done_q;

endmodule

// File: tb/tb_axis_slave_rx.sv
// Directed self-checking bench for axis_slave_rx (FIFO_DEPTH=8, MAX_BEATS=4).
module tb_axis_slave_rx;
    import axis_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    axis_slave_rx_if #(.DATA_WIDTH(32)) bus ();

    axis_slave_rx #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (8),
        .MAX_BEATS  (4)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .axis (bus.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.tvalid_in = 1'b0;
        bus.tdata_in  = '0;
        bus.tlast_in  = 1'b0;
        bus.read_in   = 1'b0;
        tick();
        tick();
        checks++; if (bus.tready_out !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", bus.tready_out); end
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.valid_out); end
        checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.data_out); end
        checks++; if (bus.last_out !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", bus.last_out); end
        checks++; if (bus.pkt_done_out !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.pkt_done_out); end
        checks++; if (bus.len_err_out !== 1'b0) begin errors++; $display("FAIL rst_lenerr got %b exp 0", bus.len_err_out); end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++; if (bus.tready_out !== 1'b0) begin errors++; $display("FAIL rel_tready_noedge got %b exp 0", bus.tready_out); end
        tick();
        checks++; if (bus.tready_out !== 1'b1) begin errors++; $display("FAIL rel_tready got %b exp 1", bus.tready_out); end
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rel_valid got %b exp 0", bus.valid_out); end
    endtask

    task automatic test_packet4();
        logic [31:0] vals [4];
        int done_cnt = 0;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        bus.read_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.tvalid_in = 1'b1;
            bus.tdata_in  = vals[i];
            bus.tlast_in  = (i == 3);
            checks++; if (bus.tready_out !== 1'b1) begin errors++; $display("FAIL p4_tready[%0d] got %b exp 1", i, bus.tready_out); end
            tick();
            checks++; if (bus.data_out !== vals[i]) begin errors++; $display("FAIL p4_data[%0d] got %h exp %h", i, bus.data_out, vals[i]); end
            checks++; if (bus.last_out !== (i == 3)) begin errors++; $display("FAIL p4_last[%0d] got %b exp %b", i, bus.last_out, (i == 3)); end
            if (bus.pkt_done_out === 1'b1) done_cnt++;
        end
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        tick();
        if (bus.pkt_done_out === 1'b1) done_cnt++;
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL p4_done_count got %0d exp 1", done_cnt); end
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL p4_drained got %b exp 0", bus.valid_out); end
        bus.read_in = 1'b0;
    endtask

    task automatic test_full();
        int next_idx = 0;
        bus.read_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.tvalid_in = 1'b1;
            bus.tdata_in  = 32'h100 + next_idx;
            bus.tlast_in  = (next_idx == 3 || next_idx == 7 || next_idx == 8);
            if (bus.tready_out === 1'b1) next_idx++;
            tick();
        end
        bus.tdata_in = 32'h100 + next_idx;
        bus.tlast_in = (next_idx == 3 || next_idx == 7 || next_idx == 8);
        checks++; if (next_idx != 8) begin errors++; $display("FAIL full_accepted got %0d exp 8", next_idx); end
        checks++; if (bus.tready_out !== 1'b0) begin errors++; $display("FAIL full_tready got %b exp 0", bus.tready_out); end
        checks++; if (bus.data_out !== 32'h100) begin errors++; $display("FAIL full_head got %h exp 100", bus.data_out); end
        bus.read_in = 1'b1;
        tick();
        bus.read_in = 1'b0;
        checks++; if (bus.tready_out !== 1'b1) begin errors++; $display("FAIL full_reopen got %b exp 1", bus.tready_out); end
        checks++; if (bus.data_out !== 32'h101) begin errors++; $display("FAIL full_head2 got %h exp 101", bus.data_out); end
        tick();
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        checks++; if (bus.tready_out !== 1'b0) begin errors++; $display("FAIL full_refill got %b exp 0", bus.tready_out); end
        checks++; if (bus.pkt_done_out !== 1'b1) begin errors++; $display("FAIL full_done9 got %b exp 1", bus.pkt_done_out); end
        bus.read_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (bus.data_out !== 32'h100 + k) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", k, bus.data_out, 32'h100 + k); end
            checks++; if (bus.last_out !== (k == 3 || k == 7 || k == 8)) begin errors++; $display("FAIL drain_last[%0d] got %b", k, bus.last_out); end
            tick();
        end
        bus.read_in = 1'b0;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", bus.valid_out); end
    endtask

    task automatic test_back_to_back();
        bus.read_in   = 1'b1;
        bus.tvalid_in = 1'b1;
        bus.tdata_in  = 32'hA0;
        bus.tlast_in  = 1'b1;
        tick();
        checks++; if (bus.pkt_done_out !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", bus.pkt_done_out); end
        checks++; if (bus.data_out !== 32'hA0 || bus.last_out !== 1'b1) begin errors++; $display("FAIL b2b_beat1 got %h/%b exp a0/1", bus.data_out, bus.last_out); end
        bus.tdata_in = 32'hB0;
        bus.tlast_in = 1'b0;
        tick();
        checks++; if (bus.pkt_done_out !== 1'b0) begin errors++; $display("FAIL b2b_nodone got %b exp 0", bus.pkt_done_out); end
        checks++; if (bus.data_out !== 32'hB0 || bus.last_out !== 1'b0) begin errors++; $display("FAIL b2b_beat2 got %h/%b exp b0/0", bus.data_out, bus.last_out); end
        bus.tdata_in = 32'hC0;
        bus.tlast_in = 1'b1;
        tick();
        checks++; if (bus.pkt_done_out !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", bus.pkt_done_out); end
        checks++; if (bus.data_out !== 32'hC0 || bus.last_out !== 1'b1) begin errors++; $display("FAIL b2b_beat3 got %h/%b exp c0/1", bus.data_out, bus.last_out); end
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        tick();
        checks++; if (bus.pkt_done_out !== 1'b0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_end got done %b valid %b exp 0/0", bus.pkt_done_out, bus.valid_out); end
        bus.read_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.read_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.tvalid_in = 1'b1;
            bus.tdata_in  = 32'hD1 + i;
            bus.tlast_in  = 1'b0;
            tick();
        end
        bus.tvalid_in = 1'b0;
        checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 32'hD1) begin errors++; $display("FAIL mid_buffered got %b/%h exp 1/d1", bus.valid_out, bus.data_out); end
        RST = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", bus.valid_out); end
        checks++; if (bus.tready_out !== 1'b0) begin errors++; $display("FAIL mid_tready got %b exp 0", bus.tready_out); end
        checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL mid_data got %h exp 0", bus.data_out); end
        tick();
        @(negedge CLK);
        RST = 1'b1;
        tick();
        checks++; if (bus.tready_out !== 1'b1) begin errors++; $display("FAIL mid_rel_tready got %b exp 1", bus.tready_out); end
        // With the length check, a stale beat count would force E1 to last here.
        bus.read_in   = 1'b1;
        bus.tvalid_in = 1'b1;
        bus.tdata_in  = 32'hE1;
        bus.tlast_in  = 1'b0;
        tick();
        checks++; if (bus.data_out !== 32'hE1 || bus.last_out !== 1'b0 || bus.pkt_done_out !== 1'b0) begin errors++; $display("FAIL mid_e1 got %h/%b/%b exp e1/0/0", bus.data_out, bus.last_out, bus.pkt_done_out); end
        bus.tdata_in = 32'hE2;
        bus.tlast_in = 1'b1;
        tick();
        checks++; if (bus.data_out !== 32'hE2 || bus.last_out !== 1'b1 || bus.pkt_done_out !== 1'b1) begin errors++; $display("FAIL mid_e2 got %h/%b/%b exp e2/1/1", bus.data_out, bus.last_out, bus.pkt_done_out); end
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        tick();
        checks++; if (bus.len_err_out !== 1'b0) begin errors++; $display("FAIL pre_len_err got %b exp 0", bus.len_err_out); end
        bus.read_in = 1'b0;
    endtask

    task automatic test_len();
        logic exp_last, exp_done, exp_err;
        bus.read_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.tvalid_in = 1'b1;
            bus.tdata_in  = 32'h50 + i;
            bus.tlast_in  = 1'b0;
            tick();
`ifdef AXIS_SLAVE_LEN_CHECK_EN
            exp_last = (i == 4);
            exp_done = (i == 4);
            exp_err  = (i >= 4);
`else
            exp_last = 1'b0;
            exp_done = 1'b0;
            exp_err  = 1'b0;
`endif
            checks++; if (bus.data_out !== 32'h50 + i) begin errors++; $display("FAIL len_data[%0d] got %h exp %h", i, bus.data_out, 32'h50 + i); end
            checks++; if (bus.last_out !== exp_last) begin errors++; $display("FAIL len_last[%0d] got %b exp %b", i, bus.last_out, exp_last); end
            checks++; if (bus.pkt_done_out !== exp_done) begin errors++; $display("FAIL len_done[%0d] got %b exp %b", i, bus.pkt_done_out, exp_done); end
            checks++; if (bus.len_err_out !== exp_err) begin errors++; $display("FAIL len_err[%0d] got %b exp %b", i, bus.len_err_out, exp_err); end
        end
        // Beat 7 closes the packet; with the check it is only beat 3 of the new packet.
        bus.tdata_in = 32'h57;
        bus.tlast_in = 1'b1;
        tick();
        bus.tvalid_in = 1'b0;
        bus.tlast_in  = 1'b0;
        checks++; if (bus.last_out !== 1'b1 || bus.pkt_done_out !== 1'b1) begin errors++; $display("FAIL len_close got last %b done %b exp 1/1", bus.last_out, bus.pkt_done_out); end
        tick();
`ifdef AXIS_SLAVE_LEN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        checks++; if (bus.len_err_out !== exp_err) begin errors++; $display("FAIL len_sticky got %b exp %b", bus.len_err_out, exp_err); end
        checks++; if (bus.pkt_done_out !== 1'b0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL len_end got done %b valid %b exp 0/0", bus.pkt_done_out, bus.valid_out); end
        bus.read_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_packet4();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
